// File: rtl/conv_window_feeder.sv
// Producer side of the 5-tap convolution datapath: builds a stride-1 sliding
// window from a valid/ready sample stream and holds the kernel/bias config bank.
module conv_window_feeder #(
  parameter int WIDTH_DATA   = 16,
  parameter int WIDTH_KERNEL = 8,
  parameter int LINE_LEN     = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cfg_we,
  input  logic [2:0]              cfg_addr,
  input  logic [WIDTH_KERNEL-1:0] cfg_wdata,
  input  logic                    start,
  input  logic                    s_valid,
  input  logic [WIDTH_DATA-1:0]   s_data,
  output logic                    s_ready,
  output logic [WIDTH_DATA-1:0]   data_in1,
  output logic [WIDTH_DATA-1:0]   data_in2,
  output logic [WIDTH_DATA-1:0]   data_in3,
  output logic [WIDTH_DATA-1:0]   data_in4,
  output logic [WIDTH_DATA-1:0]   data_in5,
  output logic [WIDTH_KERNEL-1:0] kernel_in1,
  output logic [WIDTH_KERNEL-1:0] kernel_in2,
  output logic [WIDTH_KERNEL-1:0] kernel_in3,
  output logic [WIDTH_KERNEL-1:0] kernel_in4,
  output logic [WIDTH_KERNEL-1:0] kernel_in5,
  output logic [WIDTH_KERNEL-1:0] bias,
  output logic                    enable,
  output logic                    busy,
  output logic                    line_done,
  output logic [1:0]              state_dbg
);

  // Handshake: a sample transfers on a rising clk edge where s_valid && s_ready;
  // s_ready is decoded from state only, so it never depends on s_valid.
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  localparam logic [7:0] FILL_LAST = 8'd3;
  localparam logic [7:0] RUN_LAST  = 8'(LINE_LEN - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic       hs;

  assign s_ready   = (state == S_FILL) || (state == S_RUN);
  assign busy      = (state != S_IDLE);
  assign hs        = s_valid && s_ready;
  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_FILL;
      S_FILL: if (hs && cnt == FILL_LAST) state_nxt = S_RUN;
      S_RUN:  if (hs && cnt == RUN_LAST) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Window and counter; enable is registered so it lands one cycle after the RUN handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      data_in1  <= '0;
      data_in2  <= '0;
      data_in3  <= '0;
      data_in4  <= '0;
      data_in5  <= '0;
      enable    <= 1'b0;
      line_done <= 1'b0;
    end else begin
      enable    <= hs && (state == S_RUN);
      line_done <= (state == S_DONE);
      if (state == S_IDLE && start) begin
        cnt      <= '0;
        data_in1 <= '0;
        data_in2 <= '0;
        data_in3 <= '0;
        data_in4 <= '0;
        data_in5 <= '0;
      end else if (hs) begin
        cnt      <= cnt + 8'd1;
        data_in1 <= data_in2;
        data_in2 <= data_in3;
        data_in3 <= data_in4;
        data_in4 <= data_in5;
        data_in5 <= s_data;
      end
    end
  end

  // Config bank is writable only while idle; addresses 6 and 7 fall through.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      kernel_in1 <= '0;
      kernel_in2 <= '0;
      kernel_in3 <= '0;
      kernel_in4 <= '0;
      kernel_in5 <= '0;
      bias       <= '0;
    end else if (cfg_we && state == S_IDLE) begin
      case (cfg_addr)
        3'd0: kernel_in1 <= cfg_wdata;
        3'd1: kernel_in2 <= cfg_wdata;
        3'd2: kernel_in3 <= cfg_wdata;
        3'd3: kernel_in4 <= cfg_wdata;
        3'd4: kernel_in5 <= cfg_wdata;
        3'd5: bias       <= cfg_wdata;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/conv_window_feeder.md
Name: conv_window_feeder

Overview:
- Producer side of the 5-tap convolution datapath.
- Accepts a serial stream of activation samples over a valid/ready handshake and builds a sliding 5-sample window, stride 1, no padding.
- Presents the window on data_in1..5 with a one-cycle enable strobe per window.
- Holds the 5 kernel taps and the bias in a small config register bank and drives them to the convolution core as static values.

Parameters:
- WIDTH_DATA, 16, activation sample width (two's complement).
- WIDTH_KERNEL, 8, kernel tap and bias width (two's complement).
- LINE_LEN, 32, samples per line. Legal range is 5..255; values below 5 are illegal.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  3  0..4 select kernel tap 1..5, 5 selects bias, 6..7 are ignored.
- cfg_wdata  in  WIDTH_KERNEL  config write data.
- start  in  1  single-cycle pulse that begins one line.
- s_valid  in  1  input sample valid.
- s_data  in  WIDTH_DATA  input sample.
- s_ready  out  1  feeder can accept a sample.
- data_in1..data_in5  out  WIDTH_DATA each  window; data_in1 is the oldest sample, data_in5 the newest.
- kernel_in1..kernel_in5  out  WIDTH_KERNEL each  kernel tap registers.
- bias  out  WIDTH_KERNEL  bias register.
- enable  out  1  window valid strobe to the convolution core.
- busy  out  1  high in every state except IDLE.
- line_done  out  1  one-cycle pulse at the end of a line.

Behaviour:
- Reset: all outputs, the window shift register, the kernel and bias registers, and the sample counter go to 0. FSM goes to IDLE.
- Reset mid-line: the partial line is discarded. No enable or line_done is issued after reset releases.
- Config writes are honoured only in IDLE and are silently dropped when busy=1. A write takes effect on the next clk edge; cfg_addr 6 and 7 are no-ops.
- FSM states: IDLE, FILL, RUN, DONE.
- IDLE:
  - s_ready=0.
  - start=1 moves to FILL and clears the counter and window.
  - start together with cfg_we in the same cycle: the config write is applied and FILL is still entered.
- FILL:
  - s_ready=1.
  - Each handshake (s_valid & s_ready) shifts s_data into the window: data_in5 takes the new sample, data_in(k) takes data_in(k+1).
  - The counter increments on each handshake. After the 4th handshake, move to RUN. No enable is issued during FILL.
- RUN:
  - s_ready=1.
  - Each handshake shifts the window and increments the counter. On the next cycle enable=1 for exactly one cycle, with data_in1..5 holding samples n-4..n.
  - Cycles with no handshake give enable=0 and leave the window unchanged.
  - When the handshake that makes the counter equal LINE_LEN occurs, s_ready drops on the following cycle and the FSM moves to DONE. That final enable is still issued.
- DONE: line_done=1 for one cycle, s_ready=0, then return to IDLE.
- start outside IDLE is ignored.
- Window count per line is LINE_LEN-4.
- Latency from a RUN handshake to enable is 1 cycle. Throughput is one window per cycle with s_valid held high.
- enable is a registered output with no combinational path from s_valid.
- data_in1..5 hold their last value when enable=0; they are not zeroed.
- kernel_in1..5 and bias are raw register contents with no arithmetic; sign extension is done by the consumer.
- The counter is 8 bits wide.

Test Plan:
- Reset/config: deassert rstn, then write taps 1,2,3,4,5 (addr 0..4) and bias 0xFE (addr 5) in IDLE. Required: kernel_in1..5 = 1..5, bias = 0xFE, all other outputs 0. A write to addr 6 changes nothing.
- Full line at full throughput: LINE_LEN=8, start, then samples 10,20,...,80 with s_valid held high. Required: exactly 4 enable pulses, on consecutive cycles, with windows (10..50), (20..60), (30..70), (40..80). line_done fires 2 cycles after the last handshake; busy=0 afterwards.
- Backpressure gaps: same stream with s_valid toggling 1,0,1,0. Required: enable only in the cycle after each RUN handshake, identical window contents, no duplicated windows.
- Config while busy: during RUN, cfg_we to addr 2 with value 0x7F. Required: kernel_in3 unchanged (3). After line_done the same write sets kernel_in3 = 0x7F.
- Mid-line reset: assert rstn low after the 6th sample of a LINE_LEN=8 line. Required: all outputs 0 immediately (asynchronously), kernel regs 0. After release, no enable or line_done until a new start.
- start ignored: pulse start during FILL and during RUN. Required: no restart, counter continues, window count per line stays LINE_LEN-4.
